// File: rtl/fadd_norm.sv
// fadd_norm: two-stage FP adder normalizer (LZA coarse shift, one-bit correction).
// Define FADD_NORM_DENORM_EN to produce denormals on underflow instead of flush-to-zero.
module fadd_norm #(
    parameter int WIDTH = 25,
    parameter int EXPW  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sign,
    input  logic [EXPW-1:0]            in_exp,
    input  logic [WIDTH-1:0]           in_mant,
    input  logic [$clog2(WIDTH):0]     in_lza_cnt,
    input  logic                       in_lza_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sign,
    output logic [EXPW-1:0]            out_exp,
    output logic [WIDTH-1:0]           out_mant,
    output logic                       out_zero,
    output logic                       out_uf,
    output logic                       out_mispred
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             v1, v2, adv2;
    logic             sign1, err1, z1, uf1;
    logic [EXPW-1:0]  e1;
    logic [WIDTH-1:0] m1;

    logic             zin, uf_s1;
    logic [CW-1:0]    cs;
    logic [EXPW:0]    sh_req, sh;
    logic [EXPW-1:0]  e_s1;
    logic [WIDTH-1:0] m_s1;

    logic             need, app, uf2, zero_n, mis_n;
    logic [EXPW-1:0]  exp_n;
    logic [WIDTH-1:0] mant_n;

    assign adv2      = ~v2 | out_ready;
    assign in_ready  = ~v1 | adv2;
    assign out_valid = v2;

    // Shift is clamped to in_exp when it would underflow, so e1 never goes negative.
    always_comb begin
        zin    = ~|in_mant;
        cs     = (in_lza_cnt > CW'(WIDTH - 1)) ? CW'(WIDTH - 1) : in_lza_cnt;
        sh_req = (EXPW + 1)'(cs);
        uf_s1  = ~zin & (sh_req > {1'b0, in_exp});
        sh     = uf_s1 ? {1'b0, in_exp} : sh_req;
        m_s1   = zin ? '0 : in_mant << sh;
        e_s1   = zin ? '0 : EXPW'({1'b0, in_exp} - sh);
    end

    // A needed correction at e1==0 is itself an underflow; the clamp leaves m1 unshifted.
    always_comb begin
        need   = ~z1 & ~uf1 & (|m1) & ~m1[WIDTH-1];
        app    = need & (e1 != '0);
        uf2    = uf1 | (need & (e1 == '0));
        exp_n  = app ? e1 - EXPW'(1) : e1;
`ifdef FADD_NORM_DENORM_EN
        mant_n = app ? m1 << 1 : m1;
        zero_n = z1 | (uf2 & ~|mant_n);
`else
        mant_n = uf2 ? '0 : (app ? m1 << 1 : m1);
        zero_n = z1 | uf2;
`endif
        mis_n  = ~zero_n & (err1 ^ app);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            sign1       <= 1'b0;
            err1        <= 1'b0;
            z1          <= 1'b0;
            uf1         <= 1'b0;
            e1          <= '0;
            m1          <= '0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_mant    <= '0;
            out_zero    <= 1'b0;
            out_uf      <= 1'b0;
            out_mispred <= 1'b0;
        end else begin
            if (in_ready) begin
                v1 <= in_valid;
                if (in_valid) begin
                    sign1 <= in_sign;
                    err1  <= in_lza_err;
                    z1    <= zin;
                    uf1   <= uf_s1;
                    e1    <= e_s1;
                    m1    <= m_s1;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    out_sign    <= sign1;
                    out_exp     <= exp_n;
                    out_mant    <= mant_n;
                    out_zero    <= zero_n;
                    out_uf      <= uf2;
                    out_mispred <= mis_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_fadd_norm.sv
// tb_fadd_norm: directed + streamed checks of fadd_norm against a behavioural model.
// Honours FADD_NORM_DENORM_EN in the model the same way the design does.
module tb_fadd_norm;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic        zero;
        logic        uf;
        logic        mis;
    } res_t;

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, in_sign = 0, in_lza_err = 0;
    logic [7:0]  in_exp = 0;
    logic [24:0] in_mant = 0;
    logic [5:0]  in_lza_cnt = 0;
    logic        out_valid, out_ready = 1, out_sign, out_zero, out_uf, out_mispred;
    logic [7:0]  out_exp;
    logic [24:0] out_mant;

    fadd_norm dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_lza_cnt(in_lza_cnt), .in_lza_err(in_lza_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_exp(out_exp), .out_mant(out_mant), .out_zero(out_zero),
        .out_uf(out_uf), .out_mispred(out_mispred)
    );

    always #5 clk = ~clk;

    int   n_chk = 0, n_fail = 0, delivered = 0;
    res_t q[$];
    res_t held;
    logic hv = 0, saw_low = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Spec-level rules: coarse shift, one more bit if MSB still clear, then underflow policy.
    function automatic res_t model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                   input logic [5:0] c, input logic err);
        res_t        r;
        int          sh, t;
        logic [24:0] m1;
        logic        app;
        r = '0;
        r.sign = s;
        if (m == 0) begin
            r.zero = 1;
            return r;
        end
        sh = (c > 24) ? 24 : int'(c);
        m1 = m << sh;
        t  = (m1 != 0 && !m1[24]) ? sh + 1 : sh;
        if (t > int'(e)) begin
            r.uf = 1;
            app  = 0;
`ifdef FADD_NORM_DENORM_EN
            r.mant = m << e;
            r.zero = (r.mant == 0);
`else
            r.zero = 1;
`endif
        end else begin
            r.mant = m << t;
            r.exp  = 8'(int'(e) - t);
            app    = (t > sh);
        end
        r.mis = r.zero ? 1'b0 : (err ^ app);
        return r;
    endfunction

    function automatic res_t actual();
        return {out_sign, out_exp, out_mant, out_zero, out_uf, out_mispred};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) hv = 0;
        else begin
            if (hv) chk("stall_hold", {out_valid, actual()}, {1'b1, held});
            hv   = out_valid && !out_ready;
            held = actual();
            if (in_valid && !in_ready) saw_low = 1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    chk("result", actual(), q.pop_front());
                    delivered++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_sign, in_exp, in_mant, in_lza_cnt, in_lza_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge on which the beat was accepted; leaves in_valid high.
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic [5:0] c, input logic err);
        int k = 0;
        in_valid = 1; in_sign = s; in_exp = e; in_mant = m; in_lza_cnt = c; in_lza_err = err;
        forever begin
            @(negedge clk);
            if (in_ready || k == 50) break;
            k++;
        end
        if (k == 50) chk("accept_timeout", 1, 0);
        step();
    endtask

    task automatic drain();
        int k = 0;
        in_valid = 0;
        while (q.size() != 0 && k < 50) begin
            step();
            k++;
        end
        if (k == 50) chk("drain_timeout", 1, 0);
    endtask

    typedef struct packed {
        logic s; logic [7:0] e; logic [24:0] m; logic [5:0] c; logic err;
    } vec_t;

    vec_t vecs[10] = '{
        '{1'b0, 8'd100, 25'h0100000, 6'd4,  1'b0},
        '{1'b0, 8'd100, 25'h0200000, 6'd2,  1'b1},
        '{1'b0, 8'd100, 25'h0200000, 6'd2,  1'b0},
        '{1'b1, 8'd50,  25'h0000000, 6'd25, 1'b0},
        '{1'b0, 8'd3,   25'h0000100, 6'd16, 1'b0},
        '{1'b1, 8'd2,   25'h0200000, 6'd2,  1'b1},
        '{1'b0, 8'd3,   25'h0000100, 6'd15, 1'b1},
        '{1'b1, 8'd200, 25'h1FFFFFF, 6'd0,  1'b0},
        '{1'b0, 8'd24,  25'h0000001, 6'd24, 1'b0},
        '{1'b0, 8'd10,  25'h0000003, 6'd22, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        res_t r;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", actual(), 0);
        rst_n = 1;

        r = model(0, 100, 25'h0100000, 4, 0);
        chk("pin_shift4", r, {1'b0, 8'd96, 25'h1000000, 3'b000});
        r = model(0, 100, 25'h0200000, 2, 1);
        chk("pin_corr_err1", r, {1'b0, 8'd97, 25'h1000000, 3'b000});
        r = model(0, 100, 25'h0200000, 2, 0);
        chk("pin_corr_err0", r, {1'b0, 8'd97, 25'h1000000, 3'b001});
        r = model(0, 50, 25'h0, 25, 0);
        chk("pin_zero", r, {1'b0, 8'd0, 25'h0, 3'b100});
        r = model(0, 3, 25'h0000100, 16, 0);
`ifdef FADD_NORM_DENORM_EN
        chk("pin_uf", r, {1'b0, 8'd0, 25'h0000800, 3'b010});
`else
        chk("pin_uf", r, {1'b0, 8'd0, 25'h0, 3'b110});
`endif

        step();
        foreach (vecs[i]) send(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].c, vecs[i].err);
        drain();

        send(0, 100, 25'h0200000, 2, 1);
        in_valid = 0;
        chk("lat_cycle1", out_valid, 0);
        step();
        chk("lat_cycle2", out_valid, 1);
        drain();

        base = delivered;
        fork
            for (int i = 0; i < 8; i++) begin
                logic [24:0] m;
                int lz;
                m  = 25'($urandom) | 25'h1;
                lz = 0;
                while (!m[24 - lz]) lz++;
                if (lz > 0 && $urandom_range(0, 1) == 1) lz--;
                send(1'($urandom), 8'($urandom_range(0, 40)), m, 6'(lz), 1'($urandom));
            end
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 0;
                repeat (4) @(posedge clk);
                #2 out_ready = 1;
            end
        join
        drain();
        chk("stream_delivered", delivered - base, 8);
        chk("stream_in_ready_low", saw_low, 1);

        out_ready = 0;
        send(0, 100, 25'h0100000, 4, 0);
        send(1, 90, 25'h0200000, 2, 0);
        in_valid = 0;
        rst_n = 0;
        q.delete();
        step();
        rst_n = 1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_stale", out_valid, 0);
        end
        send(1, 60, 25'h0000400, 14, 0);
        in_valid = 0;
        chk("midrst_lat1", out_valid, 0);
        step();
        chk("midrst_lat2", out_valid, 1);
        drain();
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
